// File: rtl/vdas_pkg.sv
// Shared types and constants for the sample packer and its FIFO.
// Frame length and the CRC helpers depend on SAMPLE_PACKER_CRC_EN.
package vdas_pkg;

  localparam logic [3:0] SYNC_NIBBLE = 4'hA;
  localparam logic [7:0] CRC8_POLY   = 8'h07;
  localparam int         SEQ_W       = 4;
  localparam int         SAMPLE_W    = 20;

`ifdef SAMPLE_PACKER_CRC_EN
  localparam int FRAME_LEN = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_B3,
    ST_CRC
  } packer_state_t;
`else
  localparam int FRAME_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_B3
  } packer_state_t;
`endif

  typedef struct packed {
    logic [SEQ_W-1:0]    seq;
    logic [SAMPLE_W-1:0] data;
  } sample_entry_t;

`ifdef SAMPLE_PACKER_CRC_EN
  // MSB-first CRC-8 step over one byte, no reflection, no final XOR.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                           input logic [7:0] din);
    logic [7:0] c;
    c = crc_in ^ din;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [7:0] crc8_frame(input sample_entry_t e);
    logic [7:0] c;
    c = crc8_byte(8'h00, {SYNC_NIBBLE, e.seq});
    c = crc8_byte(c, {4'h0, e.data[19:16]});
    c = crc8_byte(c, e.data[15:8]);
    c = crc8_byte(c, e.data[7:0]);
    return c;
  endfunction
`endif

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; the head entry is presented from the
// storage registers so the consumer can capture it on the same edge it pops.
module sync_fifo
  import vdas_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_count == (AW + 1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // A write into a full FIFO is legal when a read frees a slot on the same edge.
  assign w_rd = i_rd_en && !o_empty;
  assign w_wr = i_wr_en && (!o_full || w_rd);

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sample_packer.sv
// Buffers tagged 20-bit samples and streams them as byte frames with drop detection.
// Define SAMPLE_PACKER_CRC_EN to append a CRC-8 byte to every frame.
module sample_packer
  import vdas_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   overflow,
  input  logic                   clr_ovf,
  output logic [$clog2(DEPTH):0] fill
);

  packer_state_t       r_state;
  logic [SEQ_W-1:0]    r_seq;
  logic [SAMPLE_W-1:0] r_data;
  sample_entry_t       w_wr_entry;
  sample_entry_t       w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_last_state;
  logic                w_pop;
  logic                w_accept;
  logic                w_drop;
`ifdef SAMPLE_PACKER_CRC_EN
  logic [7:0]          r_crc;

  assign w_last_state = (r_state == ST_CRC);
`else
  assign w_last_state = (r_state == ST_B3);
`endif

  // Popping on the final-byte handshake keeps frames back-to-back with no bubble.
  assign w_pop      = !w_empty && ((r_state == ST_IDLE) || (w_last_state && out_ready));
  assign w_accept   = in_valid && (!w_full || w_pop);
  assign w_drop     = in_valid && !w_accept;
  assign w_wr_entry = {r_seq, in_data};

  sync_fifo #(
    .WIDTH ($bits(sample_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_accept),
    .i_wr_data (w_wr_entry),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (fill)
  );

  // The sequence counter advances on dropped samples too, so gaps are visible downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq    <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid) r_seq <= r_seq + 1'b1;
      if (w_drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_data    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef SAMPLE_PACKER_CRC_EN
      r_crc     <= '0;
`endif
    end else if (w_pop) begin
      r_data    <= w_head.data;
      out_data  <= {SYNC_NIBBLE, w_head.seq};
      out_valid <= 1'b1;
      out_last  <= 1'b0;
      r_state   <= ST_B0;
`ifdef SAMPLE_PACKER_CRC_EN
      r_crc     <= crc8_frame(w_head);
`endif
    end else if (w_last_state && out_ready) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      r_state   <= ST_IDLE;
    end else if (out_ready) begin
      unique case (r_state)
        ST_B0: begin
          out_data <= {4'h0, r_data[19:16]};
          r_state  <= ST_B1;
        end
        ST_B1: begin
          out_data <= r_data[15:8];
          r_state  <= ST_B2;
        end
        ST_B2: begin
          out_data <= r_data[7:0];
`ifdef SAMPLE_PACKER_CRC_EN
          out_last <= 1'b0;
`else
          out_last <= 1'b1;
`endif
          r_state  <= ST_B3;
        end
`ifdef SAMPLE_PACKER_CRC_EN
        ST_B3: begin
          out_data <= r_crc;
          out_last <= 1'b1;
          r_state  <= ST_CRC;
        end
`endif
        default: r_state <= r_state;
      endcase
    end
  end

endmodule
